data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter NUM_SETS, 8, number of direct-mapped lines (power of 2, ≥2).
REQ-002 Parameter BLOCK_SIZE, 1, words per line (power of 2); it matches the data memory's BLOCK_SIZE.
REQ-003 Clk  input  1  clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 Address  input  32  CPU byte address; bits [1:0] ignored.
REQ-006 MemRead  input  1  CPU load request (lw).
REQ-007 MemWrite  input  1  CPU store request (sw); wins if MemRead is also high.
REQ-008 WriteData  input  32  CPU store data.
REQ-009 ReadData  output  32  load data to CPU.
REQ-010 Stall  output  1  CPU holds the current request while high.
REQ-011 MemAddress  output  32  address to data memory.
REQ-012 ReadMiss  output  1  one-cycle line-fill request to memory.
REQ-013 MemWriteThrough  output  1  one-cycle write-through request to memory.
REQ-014 MemWriteData  output  32  store word to memory.
REQ-015 MemReadData  input  32*BLOCK_SIZE  fill block from memory; word i at bits [32i+31:32i].
REQ-016 ReadReady  input  1  memory fill complete; MemReadData valid this cycle only.
REQ-017 WriteReady  input  1  memory write complete.

Function
REQ-018 Address split: [1:0] byte, next log2(BLOCK_SIZE) bits word offset, next log2(NUM_SETS) bits index, remainder tag.
REQ-019 Per line storage: valid bit, tag, BLOCK_SIZE data words.
REQ-020 Hit = valid[index] && tag match; combinational from Address.
REQ-021 States: IDLE, FILL, WRITE_WAIT.
REQ-022 IDLE, load hit: ReadData = cached word same cycle, Stall=0, no memory request.
REQ-023 IDLE, load miss: Stall=1, ReadMiss=1 for exactly this cycle, MemAddress = block-aligned Address; request latched; next state FILL.
REQ-024 IDLE, store hit: cached word updated at the edge, MemWriteThrough=1 for this cycle, Stall=1; next state WRITE_WAIT.
REQ-025 IDLE, store miss, BLOCK_SIZE=1: ReadMiss=1 and MemWriteThrough=1 together for this cycle, Stall=1; next state FILL (write-allocate).
REQ-026 IDLE, store miss, BLOCK_SIZE>1: MemWriteThrough only, line untouched (no-allocate); next state WRITE_WAIT.
REQ-027 Stores use MemAddress = word-aligned Address; MemWriteData = WriteData.
REQ-028 MemAddress, MemWriteData are driven from latched registers and held stable from issue cycle until the Ready cycle.
REQ-029 ReadMiss/MemWriteThrough are never high outside the IDLE issue cycle (memory re-samples every idle cycle).
REQ-030 FILL: Stall=1 until ReadReady; in the ReadReady cycle Stall=0, the line is written from MemReadData with tag and valid set at the edge, and a load's ReadData = requested word of MemReadData (bypass).
REQ-031 Store-allocate fill: the stored word overrides MemReadData's word at its offset (memory returns the pre-write value).
REQ-032 WRITE_WAIT: Stall=1 until WriteReady; in the WriteReady cycle Stall=0.
REQ-033 Ready cycle → IDLE next edge; Ready inputs arriving in IDLE are ignored.
REQ-034 No request (MemRead=MemWrite=0) in IDLE: Stall=0, ReadData=0.
REQ-035 Every completed CPU request issues at most one memory transaction.

Reset
REQ-036 Rst high: state IDLE, all valid bits 0, latched registers 0, Stall/ReadMiss/MemWriteThrough 0, ReadData 0, MemAddress 0, MemWriteData 0.
REQ-037 Rst mid-FILL or mid-WRITE_WAIT aborts without updating any line; the data memory shares Rst and aborts too.

Structure
REQ-038 Shared package holds state encodings (IDLE=2'b00, FILL=2'b01, WRITE_WAIT=2'b10) and address-field width functions.
REQ-039 One sub-module, cache_array (tag/valid/data storage, combinational read, synchronous write); controller FSM lives in data_cache.

Verification
REQ-040 Reset, load 0x10 → Stall 1, one ReadMiss pulse, MemAddress 0x10; ReadReady with data 0xDEADBEEF → Stall 0, ReadData 0xDEADBEEF same cycle.
REQ-041 Repeat load 0x10 → hit, Stall 0, ReadData 0xDEADBEEF, no ReadMiss.
REQ-042 Store 0x10=0x12345678 (hit) → one MemWriteThrough pulse, Stall held until WriteReady; following load 0x10 hits returning 0x12345678.
REQ-043 Store miss 0x24=0xCAFEF00D (BLOCK_SIZE=1) → ReadMiss and MemWriteThrough same cycle; fill returns 0x0 → load 0x24 hits returning 0xCAFEF00D.
REQ-044 Conflict: load 0x00 then load 0x20 (NUM_SETS=8, same index) → second misses, evicts; load 0x00 misses again.
REQ-045 Rst asserted 5 cycles into FILL → Stall 0 immediately, state IDLE, load 0x10 then misses.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds the controller state encodings and the address-field width helpers.
// Both the controller and the storage array derive their field widths from here.
package data_cache_pkg;

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_FILL       = 2'b01;
  localparam logic [1:0] ST_WRITE_WAIT = 2'b10;

  localparam int WORD_W = 32;

  // Ceiling log2 for elaboration-time widths; returns 0 for value 1.
  function automatic int log2_int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int offset_bits(input int block_size);
    return log2_int(block_size);
  endfunction

  function automatic int index_bits(input int num_sets);
    return log2_int(num_sets);
  endfunction

  // Tag is what is left of the word address after index and offset.
  function automatic int tag_bits(input int num_sets, input int block_size);
    return 30 - log2_int(num_sets) - log2_int(block_size);
  endfunction

endpackage

// File: rtl/data_cache_cache_array.sv
// Tag/valid/data storage for the direct-mapped cache.
// Reads are combinational from rd_index; writes land on the rising edge.
// Valid bits clear on reset; tag and data contents are don't-care until valid.
module cache_array
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS   = 8,
  parameter int BLOCK_SIZE = 1,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 27
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [IDX_W-1:0]             rd_index,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [WORD_W*BLOCK_SIZE-1:0] rd_block,
  input  logic                         wr_en,
  input  logic                         wr_fill,
  input  logic [IDX_W-1:0]             wr_index,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [BLOCK_SIZE-1:0]        wr_mask,
  input  logic [WORD_W*BLOCK_SIZE-1:0] wr_block
);

  logic [NUM_SETS-1:0]           valid;
  logic [TAG_W-1:0]              tags [NUM_SETS];
  logic [WORD_W*BLOCK_SIZE-1:0]  data [NUM_SETS];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_block = data[rd_index];

  // Valid bits: cleared by reset, set only when a whole line is filled.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid <= '0;
    end else if (wr_en && wr_fill) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag on fill, data words under the per-word write mask.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      if (wr_fill) tags[wr_index] <= wr_tag;
      for (int w = 0; w < BLOCK_SIZE; w++) begin
        if (wr_mask[w]) data[wr_index][w*WORD_W +: WORD_W] <= wr_block[w*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through data cache: load hits return data the same cycle.
// Misses and every store hold Stall until the memory's Ready pulse (bypass on fill).
// Memory requests are single-cycle pulses issued from IDLE; address/data held from latches.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS   = 8,
  parameter int BLOCK_SIZE = 1
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [31:0]                  Address,
  input  logic                         MemRead,
  input  logic                         MemWrite,
  input  logic [31:0]                  WriteData,
  output logic [31:0]                  ReadData,
  output logic                         Stall,
  output logic [31:0]                  MemAddress,
  output logic                         ReadMiss,
  output logic                         MemWriteThrough,
  output logic [31:0]                  MemWriteData,
  input  logic [WORD_W*BLOCK_SIZE-1:0] MemReadData,
  input  logic                         ReadReady,
  input  logic                         WriteReady
);

  localparam int OFF_W = offset_bits(BLOCK_SIZE);
  localparam int IDX_W = index_bits(NUM_SETS);
  localparam int TAG_W = tag_bits(NUM_SETS, BLOCK_SIZE);
  localparam int BLK_W = WORD_W * BLOCK_SIZE;

  logic [1:0]  state, state_nxt;
  logic [31:0] mem_addr_q, mem_wdata_q, req_addr_q;
  logic        req_store_q;
  logic        latch_en;

  logic [31:0]      word_addr, block_addr, cur_off, req_off;
  logic [IDX_W-1:0] cur_index, req_index;
  logic [TAG_W-1:0] cur_tag, req_tag;
  logic             hit;

  logic             arr_valid;
  logic [TAG_W-1:0] arr_tag;
  logic [BLK_W-1:0] arr_block;
  logic             wr_en, wr_fill;
  logic [IDX_W-1:0] wr_index;
  logic [TAG_W-1:0] wr_tag;
  logic [BLOCK_SIZE-1:0] wr_mask;
  logic [BLK_W-1:0] wr_block;

  function automatic logic [31:0] word_of(input logic [BLK_W-1:0] blk, input logic [31:0] off);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (off == 32'(i)) w = blk[i*WORD_W +: WORD_W];
    end
    return w;
  endfunction

  // Address fields of the live CPU request and of the latched one.
  assign word_addr  = Address & 32'hFFFF_FFFC;
  assign block_addr = Address & ~(32'(BLOCK_SIZE * 4) - 32'd1);
  assign cur_off    = (Address >> 2) & 32'(BLOCK_SIZE - 1);
  assign cur_index  = IDX_W'(Address >> (2 + OFF_W));
  assign cur_tag    = TAG_W'(Address >> (2 + OFF_W + IDX_W));
  assign req_off    = (req_addr_q >> 2) & 32'(BLOCK_SIZE - 1);
  assign req_index  = IDX_W'(req_addr_q >> (2 + OFF_W));
  assign req_tag    = TAG_W'(req_addr_q >> (2 + OFF_W + IDX_W));

  assign hit = arr_valid && (arr_tag == cur_tag);

  cache_array #(
    .NUM_SETS(NUM_SETS), .BLOCK_SIZE(BLOCK_SIZE), .IDX_W(IDX_W), .TAG_W(TAG_W)
  ) u_array (
    .Clk(Clk), .Rst(Rst),
    .rd_index(cur_index), .rd_valid(arr_valid), .rd_tag(arr_tag), .rd_block(arr_block),
    .wr_en(wr_en), .wr_fill(wr_fill), .wr_index(wr_index), .wr_tag(wr_tag),
    .wr_mask(wr_mask), .wr_block(wr_block)
  );

  // Controller: outputs, array write port and next state. Everything quiet under reset.
  always_comb begin
    state_nxt       = state;
    Stall           = 1'b0;
    ReadData        = '0;
    ReadMiss        = 1'b0;
    MemWriteThrough = 1'b0;
    MemAddress      = mem_addr_q;
    MemWriteData    = mem_wdata_q;
    latch_en        = 1'b0;
    wr_en           = 1'b0;
    wr_fill         = 1'b0;
    wr_index        = cur_index;
    wr_tag          = cur_tag;
    wr_mask         = '0;
    wr_block        = '0;
    if (!Rst) begin
      case (state)
        ST_IDLE: begin
          if (MemWrite) begin
            Stall           = 1'b1;
            MemWriteThrough = 1'b1;
            MemAddress      = word_addr;
            MemWriteData    = WriteData;
            latch_en        = 1'b1;
            if (hit) begin
              wr_en    = 1'b1;
              wr_block = {BLOCK_SIZE{WriteData}};
              for (int i = 0; i < BLOCK_SIZE; i++) wr_mask[i] = (cur_off == 32'(i));
              state_nxt = ST_WRITE_WAIT;
            end else if (BLOCK_SIZE == 1) begin
              // single-word lines: allocate on a store miss, memory fills in parallel
              ReadMiss  = 1'b1;
              state_nxt = ST_FILL;
            end else begin
              state_nxt = ST_WRITE_WAIT;
            end
          end else if (MemRead) begin
            if (hit) begin
              ReadData = word_of(arr_block, cur_off);
            end else begin
              Stall      = 1'b1;
              ReadMiss   = 1'b1;
              MemAddress = block_addr;
              latch_en   = 1'b1;
              state_nxt  = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (ReadReady) begin
            wr_en    = 1'b1;
            wr_fill  = 1'b1;
            wr_index = req_index;
            wr_tag   = req_tag;
            wr_mask  = '1;
            // memory returns the pre-store value, so the stored word wins at its offset
            for (int i = 0; i < BLOCK_SIZE; i++) begin
              wr_block[i*WORD_W +: WORD_W] = (req_store_q && req_off == 32'(i))
                                             ? mem_wdata_q : MemReadData[i*WORD_W +: WORD_W];
            end
            if (!req_store_q) ReadData = word_of(MemReadData, req_off);
            state_nxt = ST_IDLE;
          end else begin
            Stall = 1'b1;
          end
        end
        ST_WRITE_WAIT: begin
          if (WriteReady) state_nxt = ST_IDLE;
          else            Stall     = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register and request latches; the latches drive the memory side while waiting.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_addr_q  <= '0;
      req_store_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        mem_addr_q  <= MemAddress;
        mem_wdata_q <= MemWriteData;
        req_addr_q  <= word_addr;
        req_store_q <= MemWrite;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache with a set-level cache model and a memory model.
// Each request is driven after a rising edge and checked at the following falling edge.
// Memory Ready latency is chosen randomly; the CPU side holds requests while stalled.
module tb_data_cache;

  localparam int NS = 8;
  localparam int BS = 1;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Address, WriteData, ReadData, MemAddress, MemWriteData;
  logic        MemRead, MemWrite, Stall, ReadMiss, MemWriteThrough, ReadReady, WriteReady;
  logic [32*BS-1:0] MemReadData;

  int vectors = 0;
  int miscompares = 0;

  // model: per-set valid / tag / word, plus a sparse backing memory
  bit          m_valid [NS];
  logic [31:0] m_tag   [NS];
  logic [31:0] m_data  [NS];
  logic [31:0] mem [logic [31:0]];

  bit          last_miss;
  logic [31:0] last_rdata;

  data_cache #(.NUM_SETS(NS), .BLOCK_SIZE(BS)) dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
    .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .MemAddress(MemAddress),
    .ReadMiss(ReadMiss), .MemWriteThrough(MemWriteThrough), .MemWriteData(MemWriteData),
    .MemReadData(MemReadData), .ReadReady(ReadReady), .WriteReady(WriteReady)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // One CPU request from issue to completion, checking every cycle against the model.
  task automatic do_req(input bit ld, input bit st, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] wa, tag, fillw;
    int          set, lat;
    bit          hit;
    wa  = addr & 32'hFFFF_FFFC;
    set = int'((wa >> 2) % NS);
    tag = wa >> 5;
    hit = m_valid[set] && (m_tag[set] == tag);
    @(posedge Clk); #1;
    MemRead = ld; MemWrite = st; Address = addr; WriteData = wd;
    ReadReady = 1'b0; WriteReady = 1'b0; MemReadData = $urandom;
    if (!ld && !st) begin
      // stray Ready pulses while idle must be ignored
      ReadReady  = 1'($urandom_range(0, 1));
      WriteReady = 1'($urandom_range(0, 1));
    end
    @(negedge Clk);
    last_miss = !hit;
    if (!ld && !st) begin
      chk("idle_stall", 32'(Stall), 0);
      chk("idle_rdata", ReadData, 0);
      chk("idle_rmiss", 32'(ReadMiss), 0);
      chk("idle_mwt", 32'(MemWriteThrough), 0);
      return;
    end
    if (st) begin
      chk("st_issue_stall", 32'(Stall), 1);
      chk("st_issue_mwt", 32'(MemWriteThrough), 1);
      chk("st_issue_rmiss", 32'(ReadMiss), 32'(!hit));
      chk("st_issue_addr", MemAddress, wa);
      chk("st_issue_wdata", MemWriteData, wd);
      if (hit) m_data[set] = wd;
      lat = $urandom_range(0, 4);
      repeat (lat) begin
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("st_wait_stall", 32'(Stall), 1);
        chk("st_wait_pulses", {30'b0, ReadMiss, MemWriteThrough}, 0);
        chk("st_wait_addr", MemAddress, wa);
        chk("st_wait_wdata", MemWriteData, wd);
      end
      @(posedge Clk); #1;
      if (hit) begin
        WriteReady = 1'b1;
      end else begin
        fillw = mem_rd(wa);
        ReadReady = 1'b1;
        MemReadData = fillw;
      end
      @(negedge Clk);
      chk("st_done_stall", 32'(Stall), 0);
      chk("st_done_pulses", {30'b0, ReadMiss, MemWriteThrough}, 0);
      chk("st_done_addr", MemAddress, wa);
      if (!hit) begin
        m_valid[set] = 1'b1;
        m_tag[set]   = tag;
        m_data[set]  = wd;
      end
      mem[wa] = wd;
    end else if (hit) begin
      chk("ld_hit_stall", 32'(Stall), 0);
      chk("ld_hit_rdata", ReadData, m_data[set]);
      chk("ld_hit_pulses", {30'b0, ReadMiss, MemWriteThrough}, 0);
    end else begin
      chk("ld_miss_stall", 32'(Stall), 1);
      chk("ld_miss_rmiss", 32'(ReadMiss), 1);
      chk("ld_miss_mwt", 32'(MemWriteThrough), 0);
      chk("ld_miss_addr", MemAddress, wa);
      lat = $urandom_range(0, 4);
      repeat (lat) begin
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("ld_wait_stall", 32'(Stall), 1);
        chk("ld_wait_pulses", {30'b0, ReadMiss, MemWriteThrough}, 0);
        chk("ld_wait_addr", MemAddress, wa);
      end
      @(posedge Clk); #1;
      fillw = mem_rd(wa);
      ReadReady = 1'b1;
      MemReadData = fillw;
      @(negedge Clk);
      chk("ld_fill_stall", 32'(Stall), 0);
      chk("ld_fill_rdata", ReadData, fillw);
      chk("ld_fill_addr", MemAddress, wa);
      m_valid[set] = 1'b1;
      m_tag[set]   = tag;
      m_data[set]  = fillw;
    end
    last_rdata = ReadData;
  endtask

  initial begin
    logic [31:0] a, d;
    int          op;
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    mem[32'h10] = 32'hDEADBEEF;
    mem[32'h24] = 32'h0000_0000;

    // reset with a load already presented: nothing may leak out
    Rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Address = 32'h10; WriteData = 32'h55;
    ReadReady = 1'b0; WriteReady = 1'b0; MemReadData = '0;
    @(negedge Clk);
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_pulses", {30'b0, ReadMiss, MemWriteThrough}, 0);
    chk("rst_rdata", ReadData, 0);
    chk("rst_memaddr", MemAddress, 0);
    chk("rst_memwdata", MemWriteData, 0);
    @(posedge Clk); #1;
    Rst = 1'b0; MemRead = 1'b0;

    // directed: cold miss, hit, store hit, store-allocate, conflict
    do_req(1, 0, 32'h10, 0);
    chk("lit_first_miss", 32'(last_miss), 1);
    chk("lit_fill_deadbeef", last_rdata, 32'hDEADBEEF);
    do_req(1, 0, 32'h10, 0);
    chk("lit_rehit", 32'(last_miss), 0);
    chk("lit_rehit_data", last_rdata, 32'hDEADBEEF);
    do_req(0, 1, 32'h10, 32'h12345678);
    do_req(1, 0, 32'h10, 0);
    chk("lit_after_store", last_rdata, 32'h12345678);
    do_req(0, 1, 32'h24, 32'hCAFEF00D);
    chk("lit_store_miss", 32'(last_miss), 1);
    do_req(1, 0, 32'h24, 0);
    chk("lit_alloc_hit", 32'(last_miss), 0);
    chk("lit_alloc_data", last_rdata, 32'hCAFEF00D);
    do_req(1, 0, 32'h00, 0);
    do_req(1, 0, 32'h20, 0);
    chk("lit_conflict_miss", 32'(last_miss), 1);
    do_req(1, 0, 32'h00, 0);
    chk("lit_evicted_miss", 32'(last_miss), 1);

    // reset in the middle of a fill of 0x50 (same set as the cached 0x10)
    do_req(1, 0, 32'h10, 0);
    @(posedge Clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; Address = 32'h50; ReadReady = 1'b0; WriteReady = 1'b0;
    @(negedge Clk);
    chk("abort_issue_rmiss", 32'(ReadMiss), 1);
    repeat (5) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("abort_wait_stall", 32'(Stall), 1);
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    #1;
    chk("abort_stall", 32'(Stall), 0);
    chk("abort_pulses", {30'b0, ReadMiss, MemWriteThrough}, 0);
    chk("abort_memaddr", MemAddress, 0);
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0; MemRead = 1'b0;
    do_req(1, 0, 32'h10, 0);
    chk("lit_post_reset_miss", 32'(last_miss), 1);
    chk("lit_post_reset_data", last_rdata, 32'h12345678);

    // random traffic over a small address pool so sets conflict often
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      a  = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
      d  = $urandom;
      if (op < 2)      do_req(0, 0, a, d);
      else if (op < 7) do_req(1, 0, a, d);
      else             do_req(0, 1, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
